// File: rtl/alu_sequencer_if.sv
// Command, ALU-drive and result signals between the sequencer and its neighbours.
// The slave modport is the sequencer's view; master is the surrounding logic (command source, ALU, result sink).
interface alu_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [4:0]  cmd_cnt;
  logic [2:0]  aluop;
  logic [31:0] alua;
  logic [31:0] alub;
  logic [31:0] alur;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cnt, alur, res_ready,
    output cmd_ready, aluop, alua, alub, res_valid, res_data, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cnt, alur, res_ready,
    input  cmd_ready, aluop, alua, alub, res_valid, res_data, busy
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one command at a time through an external single-pass ALU; shifts iterate one bit per pass.
// Latency: 2 edges (non-shift), cnt+1 edges (shift); cmd_ready is low until the result is handshaken.
module alu_sequencer #(
  parameter logic [2:0] ADD = 3'd0,
  parameter logic [2:0] SUB = 3'd1,
  parameter logic [2:0] AND = 3'd2,
  parameter logic [2:0] OR  = 3'd3,
  parameter logic [2:0] XOR = 3'd4,
  parameter logic [2:0] NOT = 3'd5,
  parameter logic [2:0] SL  = 3'd6,
  parameter logic [2:0] SR  = 3'd7
) (
  input logic            clk,
  input logic            rst,
  alu_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state;
  logic [2:0]  op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [4:0]  cnt_r;
  logic [31:0] res_r;
  logic        rdy_r;
  logic        vld_r;
  logic        busy_r;
  logic        op_is_shift;

  always_comb op_is_shift = (op_r == SL) || (op_r == SR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      cnt_r  <= '0;
      res_r  <= '0;
      rdy_r  <= 1'b1;
      vld_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid && rdy_r) begin
            op_r   <= bus.cmd_op;
            a_r    <= bus.cmd_a;
            b_r    <= bus.cmd_b;
            cnt_r  <= bus.cmd_cnt;
            rdy_r  <= 1'b0;
            busy_r <= 1'b1;
            case (bus.cmd_op)
              SL, SR: begin
                // A zero-length shift needs no ALU pass: the operand is the result.
                if (bus.cmd_cnt == 5'd0) begin
                  res_r <= bus.cmd_a;
                  vld_r <= 1'b1;
                  state <= DONE;
                end else begin
                  state <= EXEC;
                end
              end
              ADD, SUB, AND, OR, XOR, NOT: state <= EXEC;
              default:                     state <= EXEC;
            endcase
          end
        end
        EXEC: begin
          // Shifts feed the one-bit ALU result back into A until the last pass.
          if (op_is_shift && (cnt_r > 5'd1)) begin
            a_r   <= bus.alur;
            cnt_r <= cnt_r - 5'd1;
          end else begin
            res_r <= bus.alur;
            vld_r <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            vld_r  <= 1'b0;
            rdy_r  <= 1'b1;
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          vld_r  <= 1'b0;
          rdy_r  <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.aluop     = op_r;
  assign bus.alua      = a_r;
  assign bus.alub      = b_r;
  assign bus.cmd_ready = rdy_r;
  assign bus.res_valid = vld_r;
  assign bus.res_data  = res_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed-vector bench for alu_sequencer with a behavioural one-pass ALU (shifts move one bit).
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  alu_sequencer_if ifc ();

  alu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (ifc.aluop)
      3'd0:    ifc.alur = ifc.alua + ifc.alub;
      3'd1:    ifc.alur = ifc.alua - ifc.alub;
      3'd2:    ifc.alur = ifc.alua & ifc.alub;
      3'd3:    ifc.alur = ifc.alua | ifc.alub;
      3'd4:    ifc.alur = ifc.alua ^ ifc.alub;
      3'd5:    ifc.alur = ~ifc.alua;
      3'd6:    ifc.alur = ifc.alua << 1;
      default: ifc.alur = ifc.alua >> 1;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] cnt);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_a     = a;
    ifc.cmd_b     = b;
    ifc.cmd_cnt   = cnt;
  endtask

  // Counts edges until res_valid, starting at 1 for the accept edge already taken.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!ifc.res_valid && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] cnt,
                         input logic [31:0] exp_res, input int exp_lat);
    int lat;
    check({tag, "_rdy"}, {31'd0, ifc.cmd_ready}, 32'd1);
    drive_cmd(op, a, b, cnt);
    ifc.res_ready = 1'b1;
    tick();
    ifc.cmd_valid = 1'b0;
    wait_valid(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, ifc.res_data, exp_res);
    tick();
    check({tag, "_idle"}, {30'd0, ifc.busy, ifc.res_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    logic seen;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = '0;
    ifc.cmd_a     = '0;
    ifc.cmd_b     = '0;
    ifc.cmd_cnt   = '0;
    ifc.res_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_ready", {31'd0, ifc.cmd_ready}, 32'd1);
    check("rst_flags", {30'd0, ifc.busy, ifc.res_valid}, 32'd0);
    check("rst_alu",   {29'd0, ifc.aluop} | ifc.alua | ifc.alub, 32'd0);
    check("rst_res",   ifc.res_data, 32'd0);
    rst = 1'b0;
    tick();

    // Single-pass operations
    run_cmd("add", 3'd0, 32'd5, 32'd7, 5'd0, 32'd12, 2);
    run_cmd("sub", 3'd1, 32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE, 2);
    run_cmd("not", 3'd5, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 5'd0, 32'hF0F0_F0F0, 2);
    run_cmd("and", 3'd2, 32'hF0F0_00FF, 32'hFF00_FF0F, 5'd0, 32'hF000_000F, 2);
    run_cmd("or",  3'd3, 32'h1200_0034, 32'h0045_6700, 5'd0, 32'h1245_6734, 2);
    run_cmd("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'd1, 2);

    // Shifts
    run_cmd("sl31", 3'd6, 32'd1, 32'd0, 5'd31, 32'h8000_0000, 32);
    run_cmd("sr4",  3'd7, 32'h8000_0000, 32'd0, 5'd4, 32'h0800_0000, 5);
    run_cmd("sl0",  3'd6, 32'h0000_1234, 32'd0, 5'd0, 32'h0000_1234, 1);
    run_cmd("sr1",  3'd7, 32'h0000_0003, 32'd0, 5'd1, 32'h0000_0001, 2);

    // Result held under backpressure while a second command waits
    drive_cmd(3'd4, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0);
    ifc.res_ready = 1'b0;
    tick();
    drive_cmd(3'd0, 32'd10, 32'd20, 5'd0);
    tick();
    check("hold_vld", {31'd0, ifc.res_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("hold_res", ifc.res_data, 32'h5555_5555);
      check("hold_rdy", {31'd0, ifc.cmd_ready}, 32'd0);
      tick();
    end
    check("hold_op", {29'd0, ifc.aluop}, 32'd4);
    ifc.res_ready = 1'b1;
    tick();
    ifc.res_ready = 1'b0;
    check("hand_rdy", {31'd0, ifc.cmd_ready}, 32'd1);
    check("hand_vld", {31'd0, ifc.res_valid}, 32'd0);
    tick();
    ifc.cmd_valid = 1'b0;
    check("second_acc", {31'd0, ifc.busy}, 32'd1);
    check("second_a", ifc.alua, 32'd10);
    wait_valid(lat);
    check("second_lat", lat, 2);
    check("second_res", ifc.res_data, 32'd30);
    ifc.res_ready = 1'b1;
    tick();
    ifc.res_ready = 1'b0;
    check("second_idle", {31'd0, ifc.busy}, 32'd0);

    // Reset in the middle of a shift
    drive_cmd(3'd6, 32'd1, 32'd0, 5'd10);
    tick();
    ifc.cmd_valid = 1'b0;
    tick();
    tick();
    check("mid_shift_a", ifc.alua, 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_flags", {30'd0, ifc.busy, ifc.res_valid}, 32'd0);
    check("abort_alu", {29'd0, ifc.aluop} | ifc.alua | ifc.alub, 32'd0);
    check("abort_res", ifc.res_data, 32'd0);
    check("abort_rdy", {31'd0, ifc.cmd_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      seen = seen | ifc.res_valid;
      tick();
    end
    check("abort_no_res", {31'd0, seen}, 32'd0);

    // Reset wins over a simultaneous accept
    drive_cmd(3'd0, 32'd1, 32'd1, 5'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifc.cmd_valid = 1'b0;
    check("rst_acc_busy", {31'd0, ifc.busy}, 32'd0);
    check("rst_acc_op", ifc.alua, 32'd0);
    tick();
    check("rst_acc_idle", {30'd0, ifc.busy, ifc.res_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
